// File: rtl/resource_arbiter.sv
// resource_arbiter
// Round-robin owner selection in front of one shared fixed-latency resource.
// An owner-tag shift pipeline, as deep as the resource latency, routes each
// result back to the requester that issued the matching operand.
module resource_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 32,
   parameter int RES_LAT  = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      res_in_valid,
   output logic [DATA_W-1:0]         res_in_data,
   input  logic                      res_out_valid,
   input  logic [DATA_W-1:0]         res_out_data,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      busy,
   output logic                      err_orphan
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   // Next requester index with explicit wrap, so non-power-of-2 counts work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(NUM_REQ - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // One-hot vector for a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   state_t               state_r;
   state_t               state_nxt_s;
   logic [PTR_W-1:0]     rr_ptr_r;
   logic [PTR_W-1:0]     rr_ptr_nxt_s;
   logic [PTR_W-1:0]     owner_r;
   logic [PTR_W-1:0]     owner_nxt_s;
   logic [HOLD_W-1:0]    hold_cnt_r;
   logic [HOLD_W-1:0]    hold_cnt_nxt_s;
   logic [NUM_REQ-1:0]   grant_r;
   logic [NUM_REQ-1:0]   grant_nxt_s;
   logic [PTR_W-1:0]     winner_s;
   logic                 winner_found_s;
   logic                 owner_req_s;
   logic                 issue_s;
   logic                 hold_last_s;
   logic [DATA_W-1:0]    owner_data_s;
   logic [RES_LAT-1:0]   tag_vld_r;
   logic [PTR_W-1:0]     tag_own_r [RES_LAT];
   logic                 last_vld_s;
   logic [PTR_W-1:0]     last_own_s;
   logic [NUM_REQ-1:0]   resp_valid_r;
   logic [DATA_W-1:0]    resp_data_r;
   logic                 err_orphan_r;

   // Round-robin search: first set request at or above rr_ptr, wrapping.
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      winner_s       = rr_ptr_r;
      winner_found_s = 1'b0;
      idx_v          = rr_ptr_r;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!winner_found_s && req[idx_v]) begin
            winner_s       = idx_v;
            winner_found_s = 1'b1;
         end else begin
            winner_s       = winner_s;
         end
         idx_v = ptr_inc(idx_v);
      end
   end

   // Select the current owner's operand.
   always_comb begin
      owner_data_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_r == PTR_W'(i)) begin
            owner_data_s = req_data[i*DATA_W +: DATA_W];
         end else begin
            owner_data_s = owner_data_s;
         end
      end
   end

   // Issue is combinational so the resource sees the operand in the same
   // cycle the owner still requests; reset and flush suppress it.
   assign owner_req_s = req[owner_r];
   assign issue_s     = (state_r == ST_OWNED) && owner_req_s && reset && !flush;
   assign hold_last_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));

   // Next-state logic: grant from IDLE, hold/release in OWNED, flush abort.
   always_comb begin
      state_nxt_s    = state_r;
      owner_nxt_s    = owner_r;
      rr_ptr_nxt_s   = rr_ptr_r;
      hold_cnt_nxt_s = hold_cnt_r;
      grant_nxt_s    = grant_r;
      if (flush) begin
         state_nxt_s    = ST_IDLE;
         grant_nxt_s    = {NUM_REQ{1'b0}};
         hold_cnt_nxt_s = {HOLD_W{1'b0}};
         if (state_r == ST_OWNED) begin
            rr_ptr_nxt_s = ptr_inc(owner_r);
         end else begin
            rr_ptr_nxt_s = rr_ptr_r;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (winner_found_s) begin
                  state_nxt_s    = ST_OWNED;
                  owner_nxt_s    = winner_s;
                  grant_nxt_s    = onehot(winner_s);
                  hold_cnt_nxt_s = {HOLD_W{1'b0}};
               end else begin
                  state_nxt_s    = ST_IDLE;
               end
            end
            ST_OWNED: begin
               if (!owner_req_s || hold_last_s) begin
                  // Owner stopped requesting or used its last allowed issue.
                  state_nxt_s    = ST_IDLE;
                  grant_nxt_s    = {NUM_REQ{1'b0}};
                  rr_ptr_nxt_s   = ptr_inc(owner_r);
                  hold_cnt_nxt_s = {HOLD_W{1'b0}};
               end else begin
                  hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
               end
            end
            default: begin
               state_nxt_s    = ST_IDLE;
               grant_nxt_s    = {NUM_REQ{1'b0}};
               hold_cnt_nxt_s = {HOLD_W{1'b0}};
            end
         endcase
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         owner_r    <= {PTR_W{1'b0}};
         rr_ptr_r   <= {PTR_W{1'b0}};
         hold_cnt_r <= {HOLD_W{1'b0}};
         grant_r    <= {NUM_REQ{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         owner_r    <= owner_nxt_s;
         rr_ptr_r   <= rr_ptr_nxt_s;
         hold_cnt_r <= hold_cnt_nxt_s;
         grant_r    <= grant_nxt_s;
      end
   end

   // Owner-tag shift pipeline aligned with the resource latency.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tag_vld_r <= {RES_LAT{1'b0}};
         for (int i = 0; i < RES_LAT; i++) begin
            tag_own_r[i] <= {PTR_W{1'b0}};
         end
      end else begin
         tag_vld_r[0] <= issue_s && !flush;
         tag_own_r[0] <= owner_r;
         for (int i = 1; i < RES_LAT; i++) begin
            tag_vld_r[i] <= tag_vld_r[i-1] && !flush;
            tag_own_r[i] <= tag_own_r[i-1];
         end
      end
   end

   assign last_vld_s = tag_vld_r[RES_LAT-1];
   assign last_own_s = tag_own_r[RES_LAT-1];

   // Route results to their owner; flag results without a matching tag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         resp_valid_r <= {NUM_REQ{1'b0}};
         resp_data_r  <= {DATA_W{1'b0}};
         err_orphan_r <= 1'b0;
      end else begin
         if (!flush && res_out_valid && last_vld_s) begin
            resp_valid_r <= onehot(last_own_s);
            resp_data_r  <= res_out_data;
         end else begin
            resp_valid_r <= {NUM_REQ{1'b0}};
            resp_data_r  <= resp_data_r;
         end
         if (res_out_valid && !last_vld_s) begin
            err_orphan_r <= 1'b1;
         end else begin
            err_orphan_r <= err_orphan_r;
         end
      end
   end

   assign grant        = grant_r;
   assign res_in_valid = issue_s;
   assign res_in_data  = issue_s ? owner_data_s : {DATA_W{1'b0}};
   assign resp_valid   = resp_valid_r;
   assign resp_data    = resp_data_r;
   assign busy         = (state_r == ST_OWNED) || (|tag_vld_r);
   assign err_orphan   = err_orphan_r;

endmodule

// File: tb/tb_resource_arbiter.sv
// Testbench for resource_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model and a response scoreboard.
module tb_resource_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int MH  = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            flush;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant;
   logic            res_in_valid;
   logic [DW-1:0]   res_in_data;
   logic            res_out_valid;
   logic [DW-1:0]   res_out_data;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_data;
   logic            busy;
   logic            err_orphan;

   resource_arbiter #(.NUM_REQ(N), .DATA_W(DW), .RES_LAT(LAT), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset), .flush(flush), .req(req), .req_data(req_data),
      .grant(grant), .res_in_valid(res_in_valid), .res_in_data(res_in_data),
      .res_out_valid(res_out_valid), .res_out_data(res_out_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
      .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int owner; int due;} tag_t;
   typedef struct {int due; logic [DW-1:0] data;} res_t;
   typedef struct {int owner; logic [DW-1:0] data; int cyc;} exp_t;

   tag_t tag_q[$];   // tags in flight (owner, cycle its result is due)
   res_t res_q[$];   // behavioural resource: echoes operand+1 after LAT cycles
   exp_t exp_q[$];   // scoreboard of expected responses

   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_err   = 1'b0;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance model.
   task automatic step(input bit rst_b, input bit fl, input logic [N-1:0] rq,
                       input bit spur, output int iss_owner);
      logic [N*DW-1:0] d;
      logic [N-1:0]    one_v;
      logic [N-1:0]    eg;
      logic [DW-1:0]   rod;
      logic [DW-1:0]   ed;
      bit              rov;
      bit              iss;
      bit              lv;
      int              lo;
      tag_t            t;
      res_t            r;
      exp_t            e;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
      rov = 1'b0;
      rod = $urandom;
      if (res_q.size() > 0 && res_q[0].due == cyc) begin
         rov = 1'b1;
         rod = res_q[0].data;
         void'(res_q.pop_front());
      end else if (spur) begin
         rov = 1'b1;
      end
      reset = rst_b; flush = fl; req = rq; req_data = d;
      res_out_valid = rov; res_out_data = rod;
      #3;
      one_v = 1;
      eg  = (m_owner >= 0) ? (one_v << m_owner) : '0;
      iss = rst_b && !fl && (m_owner >= 0) && rq[m_owner];
      ed  = iss ? d[m_owner*DW +: DW] : '0;
      check("grant", 64'(grant), 64'(eg));
      check("res_in_valid", 64'(res_in_valid), 64'(iss));
      check("res_in_data", 64'(res_in_data), 64'(ed));
      check("busy", 64'(busy), 64'((m_owner >= 0) || (tag_q.size() > 0)));
      check("err_orphan", 64'(err_orphan), 64'(m_err));
      iss_owner = iss ? m_owner : -1;
      if (!rst_b) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_err = 1'b0;
         tag_q.delete(); res_q.delete();
      end else begin
         lv = 1'b0; lo = 0;
         if (tag_q.size() > 0 && tag_q[0].due == cyc) begin
            lv = 1'b1; lo = tag_q[0].owner;
            void'(tag_q.pop_front());
         end
         if (rov && !lv) m_err = 1'b1;
         if (fl) begin
            tag_q.delete();
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            m_owner = -1; m_hold = 0;
         end else begin
            if (rov && lv) begin
               e.owner = lo; e.data = rod; e.cyc = cyc + 1;
               exp_q.push_back(e);
            end
            if (m_owner >= 0) begin
               if (iss) begin
                  t.owner = m_owner; t.due = cyc + LAT;
                  tag_q.push_back(t);
                  r.due = cyc + LAT; r.data = d[m_owner*DW +: DW] + 32'd1;
                  res_q.push_back(r);
                  m_hold++;
               end
               if (!rq[m_owner] || m_hold == MH) begin
                  m_ptr = (m_owner + 1) % N; m_owner = -1; m_hold = 0;
               end
            end else if (rq != '0) begin
               for (int k = 0; k < N; k++) begin
                  if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
               end
               m_hold = 0;
            end
         end
      end
   endtask

   // Response monitor: pops the scoreboard whenever the DUT presents a result.
   exp_t         mon_e;
   logic [N-1:0] mon_oh;
   always @(negedge clk) begin
      if (mon_en) begin
         if (resp_valid !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected cycle %0d: got resp_valid %b data %0h, expected none",
                        cyc, resp_valid, resp_data);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_oh = 4'b0001 << mon_e.owner;
               if (resp_valid !== mon_oh || resp_data !== mon_e.data || cyc != mon_e.cyc) begin
                  errors++;
                  $display("FAIL resp cycle %0d: got valid %b data %0h, expected valid %b data %0h at cycle %0d",
                           cyc, resp_valid, resp_data, mon_oh, mon_e.data, mon_e.cyc);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL resp_missing cycle %0d: got none, expected owner %0d data %0h",
                     cyc, exp_q[0].owner, exp_q[0].data);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int io;
      logic [N-1:0] done;
      logic [N-1:0] rq;
      bit rb, fl;
      reset = 1'b0; flush = 1'b0; req = 4'b1111; req_data = '0;
      res_out_valid = 1'b0; res_out_data = '0;
      @(posedge clk);
      mon_en = 1'b1;

      // Reset held with all requests, then first grant goes to requester 0.
      step(1'b0, 1'b0, 4'b1111, 1'b0, io);
      step(1'b1, 1'b0, 4'b1111, 1'b0, io);
      step(1'b1, 1'b0, 4'b1111, 1'b0, io);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Round robin between requesters 1 and 3, one issue each.
      step(1'b0, 1'b0, 4'b0000, 1'b0, io);
      done = '0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 4'b1010 & ~done, 1'b0, io);
         if (io >= 0) done[io] = 1'b1;
         if (done == 4'b1010) done = '0;
      end
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Hold limit with two continuous requesters.
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 4'b0011, 1'b0, io);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Overlapping results from requesters 2 and 3.
      step(1'b0, 1'b0, 4'b0000, 1'b0, io);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0100, 1'b0, io);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1000, 1'b0, io);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Flush during requester 1 ownership with two tags in flight.
      step(1'b0, 1'b0, 4'b0000, 1'b0, io);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0010, 1'b0, io);
      step(1'b1, 1'b1, 4'b0110, 1'b0, io);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0100, 1'b0, io);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Orphan on an empty pipeline, then reset together with flush clears it.
      step(1'b0, 1'b0, 4'b0000, 1'b0, io);
      step(1'b1, 1'b0, 4'b0000, 1'b1, io);
      step(1'b1, 1'b0, 4'b0000, 1'b0, io);
      step(1'b0, 1'b1, 4'b1111, 1'b0, io);
      step(1'b1, 1'b0, 4'b0000, 1'b0, io);
      step(1'b1, 1'b0, 4'b0000, 1'b0, io);

      // Random traffic.
      rq = '0;
      for (int i = 0; i < 800; i++) begin
         for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) rq[b] = ~rq[b];
         rb = ($urandom_range(199) != 0);
         fl = ($urandom_range(39) == 0);
         step(rb, fl, rq, ($urandom_range(79) == 0), io);
      end
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'b0000, 1'b0, io);
      @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
